// File: rtl/rect_fill.sv
// rect_fill: fills a solid RGB888 rectangle into a linear framebuffer, row-major; optional clipping via RECT_FILL_CLIP_EN.
// Latency: first write one cycle after command accept; done pulses one cycle after the last accepted write.
// Backpressure: out_ready low holds pixel/color/sig_write; cmd_ready is low while filling (no queueing).
module rect_fill #(
    parameter int H_RES = 800,
    parameter int V_RES = 600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x,
    input  logic [9:0]  cmd_y,
    input  logic [10:0] cmd_w,
    input  logic [10:0] cmd_h,
    input  logic [23:0] cmd_color,
    output logic        sig_write,
    output logic [19:0] pixel,
    output logic [23:0] color,
    input  logic        out_ready,
    output logic        done
);

    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [19:0] ROW_STEP = 20'(H_RES);

    if (H_RES > 1024 || V_RES > 1024 || H_RES * V_RES > (1 << 20)) begin : g_bad_geometry
        $error("rect_fill: screen geometry does not fit the 10-bit coordinates / 20-bit index");
    end

    state_t      state, state_nxt;
    logic [19:0] row_base, row_base_nxt;
    logic [19:0] pixel_nxt;
    logic [23:0] color_nxt;
    logic        sig_write_nxt;
    logic        done_nxt;
    logic [10:0] col_left, col_left_nxt;
    logic [10:0] row_left, row_left_nxt;
    logic [10:0] width_m1, width_m1_nxt;
    logic [10:0] eff_w, eff_h;
    logic [19:0] start_pix;

`ifdef RECT_FILL_CLIP_EN
    logic [10:0] room_x, room_y;

    always_comb begin
        room_x = 11'(H_RES) - 11'(cmd_x);
        room_y = 11'(V_RES) - 11'(cmd_y);
        eff_w  = '0;
        eff_h  = '0;
        // Origin off-screen collapses to an empty command.
        if (11'(cmd_x) < 11'(H_RES)) begin
            eff_w = (cmd_w < room_x) ? cmd_w : room_x;
        end
        if (11'(cmd_y) < 11'(V_RES)) begin
            eff_h = (cmd_h < room_y) ? cmd_h : room_y;
        end
    end
`else
    assign eff_w = cmd_w;
    assign eff_h = cmd_h;
`endif

    // Constant-coefficient product: only the first pixel needs it, rows advance by addition.
    assign start_pix = 20'(cmd_y) * ROW_STEP + 20'(cmd_x);

    assign cmd_ready = (state == IDLE);

    always_comb begin
        state_nxt     = state;
        sig_write_nxt = sig_write;
        pixel_nxt     = pixel;
        color_nxt     = color;
        done_nxt      = 1'b0;
        row_base_nxt  = row_base;
        col_left_nxt  = col_left;
        row_left_nxt  = row_left;
        width_m1_nxt  = width_m1;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (eff_w == '0 || eff_h == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt     = FILL;
                        sig_write_nxt = 1'b1;
                        pixel_nxt     = start_pix;
                        row_base_nxt  = start_pix;
                        color_nxt     = cmd_color;
                        width_m1_nxt  = eff_w - 11'd1;
                        col_left_nxt  = eff_w - 11'd1;
                        row_left_nxt  = eff_h - 11'd1;
                    end
                end
            end
            FILL: begin
                if (out_ready) begin
                    if (col_left != '0) begin
                        col_left_nxt = col_left - 11'd1;
                        pixel_nxt    = pixel + 20'd1;
                    end else if (row_left != '0) begin
                        row_left_nxt = row_left - 11'd1;
                        col_left_nxt = width_m1;
                        row_base_nxt = row_base + ROW_STEP;
                        pixel_nxt    = row_base + ROW_STEP;
                    end else begin
                        state_nxt     = IDLE;
                        sig_write_nxt = 1'b0;
                        done_nxt      = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            sig_write <= 1'b0;
            done      <= 1'b0;
            pixel     <= '0;
            color     <= '0;
            row_base  <= '0;
            col_left  <= '0;
            row_left  <= '0;
            width_m1  <= '0;
        end else begin
            state     <= state_nxt;
            sig_write <= sig_write_nxt;
            done      <= done_nxt;
            pixel     <= pixel_nxt;
            color     <= color_nxt;
            row_base  <= row_base_nxt;
            col_left  <= col_left_nxt;
            row_left  <= row_left_nxt;
            width_m1  <= width_m1_nxt;
        end
    end

endmodule

// File: tb/tb_rect_fill.sv
// Directed bench for rect_fill: reset, basic fill, empty command, backpressure, reset abort, back-to-back, clipping.
module tb_rect_fill;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x;
    logic [9:0]  cmd_y;
    logic [10:0] cmd_w;
    logic [10:0] cmd_h;
    logic [23:0] cmd_color;
    logic        sig_write;
    logic [19:0] pixel;
    logic [23:0] color;
    logic        out_ready;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    rect_fill dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .sig_write (sig_write),
        .pixel     (pixel),
        .color     (color),
        .out_ready (out_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [9:0] x, input logic [9:0] y,
                         input logic [10:0] w, input logic [10:0] h, input logic [23:0] c);
        cmd_x     = x;
        cmd_y     = y;
        cmd_w     = w;
        cmd_h     = h;
        cmd_color = c;
        cmd_valid = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; cmd_valid = 1'b0; out_ready = 1'b1;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        tick();
        tick();
        n_checks++;
        if (sig_write !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ctrl: sig_write=%b done=%b cmd_ready=%b, expected 0/0/1", sig_write, done, cmd_ready);
        end
        n_checks++;
        if (pixel !== 20'd0 || color !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_data: pixel=%0d color=%h, expected 0/000000", pixel, color);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [19:0] exp_pix [6] = '{20'd1610, 20'd1611, 20'd1612, 20'd2410, 20'd2411, 20'd2412};
        issue(10'd10, 10'd2, 11'd3, 11'd2, 24'hFF0000);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ready_idle: cmd_ready=%b, expected 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (sig_write !== 1'b1 || pixel !== exp_pix[i] || color !== 24'hFF0000 || cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_write%0d: sig_write=%b pixel=%0d color=%h cmd_ready=%b, expected 1/%0d/ff0000/0",
                         i, sig_write, pixel, color, cmd_ready, exp_pix[i]);
            end
            tick();
        end
        n_checks++;
        if (sig_write !== 1'b0 || done !== 1'b1 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done: sig_write=%b done=%b cmd_ready=%b, expected 0/1/1", sig_write, done, cmd_ready);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || sig_write !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: done=%b sig_write=%b, expected 0/0", done, sig_write);
        end
    endtask

    task automatic test_empty();
        issue(10'd3, 10'd3, 11'd0, 11'd5, 24'hABCDEF);
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (done !== 1'b1 || sig_write !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_done: done=%b sig_write=%b cmd_ready=%b, expected 1/0/1", done, sig_write, cmd_ready);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || sig_write !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_after: done=%b sig_write=%b cmd_ready=%b, expected 0/0/1", done, sig_write, cmd_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [19:0] exp_pix [6] = '{20'd1610, 20'd1611, 20'd1612, 20'd2410, 20'd2411, 20'd2412};
        logic [19:0] got [$];
        int  hold = 0;
        bit  seen_done = 1'b0;
        issue(10'd10, 10'd2, 11'd3, 11'd2, 24'hFF0000);
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 30 && !seen_done; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            if (done === 1'b1) begin
                seen_done = 1'b1;
            end else begin
                if (sig_write === 1'b1 && pixel === 20'd1611) hold++;
                if (sig_write === 1'b1 && out_ready) got.push_back(pixel);
                tick();
            end
        end
        out_ready = 1'b1;
        n_checks++;
        if (!seen_done) begin
            n_fail++;
            $display("FAIL bp_done_timeout: done not seen within 30 cycles, expected done");
        end
        n_checks++;
        if (got.size() != 6) begin
            n_fail++;
            $display("FAIL bp_count: writes=%0d, expected 6", got.size());
        end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_pix[i]) begin
                n_fail++;
                $display("FAIL bp_write%0d: pixel=%0d, expected %0d", i, got[i], exp_pix[i]);
            end
        end
        n_checks++;
        if (hold != 4) begin
            n_fail++;
            $display("FAIL bp_hold: pixel 1611 shown %0d cycles, expected 4", hold);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int writes = 0;
        int dones  = 0;
        issue(10'd10, 10'd2, 11'd3, 11'd2, 24'hFF0000);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (sig_write !== 1'b1 || pixel !== 20'd1612) begin
            n_fail++;
            $display("FAIL abort_third: sig_write=%b pixel=%0d, expected 1/1612", sig_write, pixel);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (sig_write !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || pixel !== 20'd0) begin
            n_fail++;
            $display("FAIL abort_reset: sig_write=%b cmd_ready=%b done=%b pixel=%0d, expected 0/1/0/0",
                     sig_write, cmd_ready, done, pixel);
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sig_write === 1'b1) writes++;
            if (done === 1'b1) dones++;
        end
        n_checks++;
        if (writes != 0 || dones != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: writes=%0d dones=%0d, expected 0/0", writes, dones);
        end
    endtask

    task automatic test_back_to_back();
        issue(10'd0, 10'd0, 11'd2, 11'd1, 24'h00FF00);
        tick();
        n_checks++;
        if (sig_write !== 1'b1 || pixel !== 20'd0 || color !== 24'h00FF00 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_a0: sig_write=%b pixel=%0d color=%h cmd_ready=%b, expected 1/0/00ff00/0",
                     sig_write, pixel, color, cmd_ready);
        end
        issue(10'd5, 10'd1, 11'd1, 11'd1, 24'h0000FF);
        tick();
        n_checks++;
        if (sig_write !== 1'b1 || pixel !== 20'd1 || color !== 24'h00FF00) begin
            n_fail++;
            $display("FAIL b2b_a1: sig_write=%b pixel=%0d color=%h, expected 1/1/00ff00", sig_write, pixel, color);
        end
        tick();
        n_checks++;
        if (done !== 1'b1 || sig_write !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_a_done: done=%b sig_write=%b cmd_ready=%b, expected 1/0/1", done, sig_write, cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (sig_write !== 1'b1 || pixel !== 20'd805 || color !== 24'h0000FF || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_b0: sig_write=%b pixel=%0d color=%h done=%b, expected 1/805/0000ff/0",
                     sig_write, pixel, color, done);
        end
        tick();
        n_checks++;
        if (done !== 1'b1 || sig_write !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_b_done: done=%b sig_write=%b, expected 1/0", done, sig_write);
        end
        tick();
    endtask

`ifdef RECT_FILL_CLIP_EN
    task automatic test_clip();
        issue(10'd798, 10'd599, 11'd5, 11'd4, 24'h123456);
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (sig_write !== 1'b1 || pixel !== 20'd479998 || color !== 24'h123456) begin
            n_fail++;
            $display("FAIL clip_w0: sig_write=%b pixel=%0d color=%h, expected 1/479998/123456", sig_write, pixel, color);
        end
        tick();
        n_checks++;
        if (sig_write !== 1'b1 || pixel !== 20'd479999) begin
            n_fail++;
            $display("FAIL clip_w1: sig_write=%b pixel=%0d, expected 1/479999", sig_write, pixel);
        end
        tick();
        n_checks++;
        if (sig_write !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL clip_done: sig_write=%b done=%b, expected 0/1", sig_write, done);
        end
        tick();
        issue(10'd800, 10'd10, 11'd4, 11'd4, 24'h654321);
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (sig_write !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL clip_offscreen: sig_write=%b done=%b, expected 0/1", sig_write, done);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
`ifdef RECT_FILL_CLIP_EN
        test_clip();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
